// File: rtl/score_round_keeper_if.sv
// Signal bundle between the score-calculator side and the round keeper.
interface score_round_keeper_if #(
  parameter int TOTAL_W = 6
) ();
  logic [3:0]         score;
  logic               score_btn;
  logic               new_game;
  logic [TOTAL_W-1:0] total;
  logic [3:0]         last_score;
  logic [3:0]         best;
  logic [3:0]         round_cnt;
  logic               score_valid;
  logic               score_err;
  logic               game_over;

  modport master (
    output score, score_btn, new_game,
    input  total, last_score, best, round_cnt, score_valid, score_err, game_over
  );

  modport slave (
    input  score, score_btn, new_game,
    output total, last_score, best, round_cnt, score_valid, score_err, game_over
  );
endinterface

// File: rtl/score_round_keeper.sv
// Per-game score keeper: edge-detects the score button, accumulates a
// saturating total, tracks best/last score and ends the game after ROUNDS.
//
// state | meaning
// PLAY  | presses are scored
// DONE  | all rounds used, presses ignored, game_over high
module score_round_keeper #(
  parameter int ROUNDS    = 5,
  parameter int TOTAL_W   = 6,
  parameter int MAX_SCORE = 10
) (
  input logic clk,
  input logic rst,
  score_round_keeper_if.slave bus
);
  typedef enum logic {PLAY, DONE} state_t;

  state_t             state_q, state_d;
  logic               btn_q, btn_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [3:0]         last_q, last_d;
  logic [3:0]         best_q, best_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic               press;
  logic [TOTAL_W:0]   sum;

  assign press = bus.score_btn & ~btn_q;
  assign sum   = {1'b0, total_q} + (TOTAL_W+1)'(bus.score);

  always_comb begin
    state_d = state_q;
    btn_d   = bus.score_btn;
    total_d = total_q;
    last_d  = last_q;
    best_d  = best_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (bus.new_game) begin
      // a press coinciding with new_game is discarded
      state_d = PLAY;
      total_d = '0;
      last_d  = '0;
      best_d  = '0;
      cnt_d   = '0;
    end else if (state_q == PLAY && press) begin
      if (bus.score <= 4'(MAX_SCORE)) begin
        total_d = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
        last_d  = bus.score;
        best_d  = (bus.score > best_q) ? bus.score : best_q;
        cnt_d   = cnt_q + 4'd1;
        valid_d = 1'b1;
        if (cnt_q + 4'd1 == 4'(ROUNDS)) state_d = DONE;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PLAY;
      btn_q   <= 1'b1;  // a button held through reset must not count
      total_q <= '0;
      last_q  <= '0;
      best_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      total_q <= total_d;
      last_q  <= last_d;
      best_q  <= best_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.total       = total_q;
  assign bus.last_score  = last_q;
  assign bus.best        = best_q;
  assign bus.round_cnt   = cnt_q;
  assign bus.score_valid = valid_q;
  assign bus.score_err   = err_q;
  assign bus.game_over   = (state_q == DONE);
endmodule

// File: doc/score_round_keeper.md
Name: score_round_keeper

Overview:
- Sequential stage directly downstream of the combinational score calculator.
- Consumes its 4-bit per-throw score (range 0..10) when the player presses the score button.
- Accumulates a running game total over a fixed number of rounds and tracks the best single-round score.
- Drives game-over and status outputs to the display/LED logic.

Parameters:
- ROUNDS, 5, rounds per game; legal range 1..15.
- TOTAL_W, 6, width of the accumulated total; total saturates at 2^TOTAL_W-1.
- MAX_SCORE, 10, largest legal per-round score from the calculator.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- score  input  4  per-round score from the score calculator.
- score_btn  input  1  score button level, already synchronised and debounced.
- new_game  input  1  level; restarts the game.
- total  output  TOTAL_W  accumulated score for the current game.
- last_score  output  4  score captured at the most recent accepted press.
- best  output  4  maximum accepted score in the current game.
- round_cnt  output  4  number of accepted rounds, 0..ROUNDS.
- score_valid  output  1  one-cycle pulse, asserted the cycle after a press is accepted.
- score_err  output  1  one-cycle pulse, asserted the cycle after a press is rejected.
- game_over  output  1  high while in DONE state.

Behaviour:
- Reset values:
  - total=0, last_score=0, best=0, round_cnt=0.
  - score_valid=0, score_err=0, game_over=0.
  - FSM=PLAY, btn_q=1. A button held through reset is not counted as a press.
- Edge detect: press = score_btn & ~btn_q; btn_q <= score_btn every cycle. A held button yields exactly one press.
- FSM states:
  - PLAY: accepts presses.
  - DONE: ignores presses; game_over=1.
- Press handling in PLAY (same edge as the detected press):
  - score is sampled on that edge. If score <= MAX_SCORE, the press is accepted:
    - total <= sat(total + score).
    - last_score <= score.
    - best <= max(best, score).
    - round_cnt <= round_cnt + 1.
    - score_valid pulses next cycle.
  - If score > MAX_SCORE, the press is rejected: no state change, round not consumed, score_err pulses next cycle.
- Saturation:
  - The sum is computed at TOTAL_W+1 bits.
  - If the sum exceeds 2^TOTAL_W-1, total holds all-ones. No wrap.
- Game end:
  - When an accepted press brings round_cnt to ROUNDS, the FSM moves to DONE on that same edge.
  - game_over is visible in the same cycle as the final score_valid pulse.
- Press in DONE: ignored. No pulses, outputs held.
- new_game:
  - Highest priority after rst, in either state.
  - Clears total, last_score, best and round_cnt; FSM to PLAY.
  - A press in the same cycle is discarded: no score_valid, no score_err.
  - While new_game is held, all presses are discarded.
- rst mid-game: returns everything to reset values on the next edge regardless of state.
- Latency: accepted press edge to updated total/best/round_cnt is 1 clock. The pulse appears in the cycle after that same edge.
- score_valid and score_err are never high together.

Test Plan:
- rst, then five presses with score=3,10,0,7,5, each held 3 cycles -> total=25, best=10, last_score=5, round_cnt=5, five score_valid pulses, game_over=1 after 5th press.
- Button held 20 cycles with score=4 -> exactly one acceptance: total=4, round_cnt=1, one score_valid pulse.
- Press with score=12 -> score_err pulse, total/round_cnt unchanged. Then press with score=6 -> accepted, total=6, round_cnt=1.
- TOTAL_W=4, ROUNDS=3, scores 10,10,10 -> total saturates at 15 after 2nd press and stays 15. best=10, game_over=1.
- In DONE, press with score=9 -> no pulse, total unchanged. new_game high for 1 cycle together with a press -> all counters 0, game_over=0, no score_valid.
- rst asserted mid-game with round_cnt=2, total=13 and score_btn held high -> all outputs 0 next cycle. No press is counted until score_btn goes low then high again.
